// File: rtl/instruction_unpacker.sv
// Front-end decode: reassembles one instruction_t from a header word plus 0-4
// argument words, widening each argument and flagging malformed headers.
package instructions;
  typedef logic [15:0] opcode_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [3:0]  argSize0;
    logic [3:0]  argSize1;
    logic [3:0]  argSize2;
    logic [3:0]  argSize3;
    logic [7:0]  flags;
    logic [63:0] arg0;
    logic [63:0] arg1;
    logic [63:0] arg2;
    logic [63:0] arg3;
  } instruction_t;
endpackage

module instruction_unpacker
  import instructions::*;
#(
  parameter int unsigned OPCODE_COUNT = 91,
  parameter int unsigned MAX_ARGS     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_instr,
  output logic         out_illegal
);

  typedef enum logic [1:0] {HEADER, ARGS, EMIT} state_t;

  state_t      state;
  logic [15:0] opcode_q;
  logic [3:0]  size_q [MAX_ARGS];
  logic [7:0]  flags_q;
  logic [MAX_ARGS-1:0] sext_q;
  logic [2:0]  count_q;
  logic [1:0]  idx_q;
  logic [63:0] arg_q [MAX_ARGS];
  logic        illegal_q;
  logic        valid_q;

  logic [2:0]  hdr_count;
  logic        hdr_bad;
  logic        unused_reserved;

  assign hdr_count       = in_data[42:40];
  assign unused_reserved = ^in_data[63:47];

  // Size codes above 3 only matter in slots that will actually carry an argument.
  always_comb begin
    hdr_bad = ({16'b0, in_data[15:0]} >= OPCODE_COUNT) || ({29'b0, hdr_count} > MAX_ARGS);
    for (int unsigned n = 0; n < MAX_ARGS; n++) begin
      if ((n < {29'b0, hdr_count}) && (in_data[16 + 4*n + 2 +: 2] != 2'b00)) begin
        hdr_bad = 1'b1;
      end
    end
  end

  function automatic logic [63:0] widen(input logic [63:0] w, input logic [1:0] sz,
                                        input logic sx);
    logic [63:0] r;
    case (sz)
      2'd0:    r = sx ? {{56{w[7]}},  w[7:0]}  : {56'b0, w[7:0]};
      2'd1:    r = sx ? {{48{w[15]}}, w[15:0]} : {48'b0, w[15:0]};
      2'd2:    r = sx ? {{32{w[31]}}, w[31:0]} : {32'b0, w[31:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign in_ready    = ~reset & ~flush & (state != EMIT);
  assign out_valid   = valid_q;
  assign out_illegal = illegal_q;
  assign out_instr   = '{opcode:   opcode_q,
                         argSize0: size_q[0], argSize1: size_q[1],
                         argSize2: size_q[2], argSize3: size_q[3],
                         flags:    flags_q,
                         arg0:     arg_q[0],  arg1:     arg_q[1],
                         arg2:     arg_q[2],  arg3:     arg_q[3]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HEADER;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      opcode_q  <= '0;
      flags_q   <= '0;
      sext_q    <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      for (int unsigned n = 0; n < MAX_ARGS; n++) begin
        size_q[n] <= '0;
        arg_q[n]  <= '0;
      end
    end else if (flush) begin
      state   <= HEADER;
      valid_q <= 1'b0;
      for (int unsigned n = 0; n < MAX_ARGS; n++) begin
        arg_q[n] <= '0;
      end
    end else begin
      case (state)
        HEADER: begin
          if (in_valid) begin
            opcode_q  <= in_data[15:0];
            flags_q   <= in_data[39:32];
            sext_q    <= in_data[46:43];
            count_q   <= hdr_count;
            idx_q     <= '0;
            illegal_q <= hdr_bad;
            for (int unsigned n = 0; n < MAX_ARGS; n++) begin
              size_q[n] <= in_data[16 + 4*n +: 4];
              arg_q[n]  <= '0;
            end
            if (hdr_bad || (hdr_count == 3'd0)) begin
              state   <= EMIT;
              valid_q <= 1'b1;
            end else begin
              state <= ARGS;
            end
          end
        end
        ARGS: begin
          if (in_valid) begin
            arg_q[idx_q] <= widen(in_data, size_q[idx_q][1:0], sext_q[idx_q]);
            idx_q        <= idx_q + 2'd1;
            if ({1'b0, idx_q} == (count_q - 3'd1)) begin
              state   <= EMIT;
              valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            state   <= HEADER;
            valid_q <= 1'b0;
          end
        end
        default: state <= HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_unpacker.sv
// Self-checking bench for instruction_unpacker: stream-level reference model,
// per-cycle output comparison, and directed cases with literal expectations.
module tb_instruction_unpacker;
  import instructions::*;

  typedef struct packed {
    instruction_t ins;
    logic         ill;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  instruction_t out_instr;
  logic         out_illegal;

  always #5 clk = ~clk;

  instruction_unpacker #(.OPCODE_COUNT(91), .MAX_ARGS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_illegal(out_illegal)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: decode straight from the header field definitions.
  function automatic exp_t model_decode(input logic [63:0] h, input logic [63:0] a [4]);
    exp_t        e;
    int          cnt;
    int          width;
    int unsigned sz;
    logic [63:0] mask;
    logic [63:0] v;
    e = '0;
    e.ins.opcode   = h[15:0];
    e.ins.argSize0 = h[19:16];
    e.ins.argSize1 = h[23:20];
    e.ins.argSize2 = h[27:24];
    e.ins.argSize3 = h[31:28];
    e.ins.flags    = h[39:32];
    cnt   = int'(h[42:40]);
    e.ill = (h[15:0] >= 16'd91) || (cnt > 4);
    for (int n = 0; n < 4; n++) begin
      sz = 32'(h[16 + 4*n +: 4]);
      if (n < cnt && sz > 3) e.ill = 1'b1;
    end
    if (!e.ill) begin
      for (int n = 0; n < cnt; n++) begin
        sz    = 32'(h[16 + 4*n +: 4]);
        width = 8 << sz;
        mask  = (width == 64) ? '1 : ((64'd1 << width) - 64'd1);
        v     = a[n] & mask;
        if (h[43 + n] && v[width - 1]) v = v | ~mask;
        case (n)
          0: e.ins.arg0 = v;
          1: e.ins.arg1 = v;
          2: e.ins.arg2 = v;
          default: e.ins.arg3 = v;
        endcase
      end
    end
    return e;
  endfunction

  logic [63:0] zero_args [4] = '{default: '0};

  function automatic int model_need(input logic [63:0] h);
    exp_t e;
    e = model_decode(h, zero_args);
    return e.ill ? 0 : int'(h[42:40]);
  endfunction

  logic [63:0] src_q [$];
  exp_t        exp_q [$];
  exp_t        got_q [$];
  logic [63:0] cur_hdr;
  logic [63:0] cur_args [4];
  int          need, got_words;
  bit          mid = 0;
  int          cyc = 0, hdr_cyc = 0, valid_cyc = 0, delivered = 0;
  logic        prev_valid = 1'b0;

  // Single compare process: sampled on the falling edge, between driver updates.
  always @(negedge clk) begin
    exp_t r;
    cyc++;
    if (reset) begin
      mid = 0;
      exp_q.delete();
    end else begin
      check("in_ready", in_ready, (!flush) && (exp_q.size() == 0));
      check("out_valid", out_valid, exp_q.size() > 0);
      if (out_valid && exp_q.size() > 0) begin
        check("out_instr", out_instr, exp_q[0].ins);
        check("out_illegal", out_illegal, exp_q[0].ill);
      end
      if (out_valid && !prev_valid) valid_cyc = cyc;
      if (flush) begin
        mid = 0;
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          r.ins = out_instr;
          r.ill = out_illegal;
          got_q.push_back(r);
          void'(exp_q.pop_front());
          delivered++;
        end
        if (in_valid && in_ready) begin
          if (!mid) begin
            cur_hdr   = in_data;
            got_words = 0;
            hdr_cyc   = cyc;
            for (int n = 0; n < 4; n++) cur_args[n] = '0;
            need = model_need(in_data);
            if (need == 0) exp_q.push_back(model_decode(cur_hdr, cur_args));
            else mid = 1;
          end else begin
            cur_args[got_words] = in_data;
            got_words++;
            if (got_words == need) begin
              exp_q.push_back(model_decode(cur_hdr, cur_args));
              mid = 0;
            end
          end
          if (src_q.size() > 0) void'(src_q.pop_front());
        end
      end
    end
    prev_valid = out_valid;
  end

  int valid_pct = 100;
  int ready_pct = 100;
  bit flush_req = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    flush     = flush_req;
    flush_req = 0;
    if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      in_valid = 1'b1;
      in_data  = src_q[0];
    end else begin
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
    end
    out_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || mid) && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", n < budget, 1'b1);
  endtask

  task automatic chk_got(input int i, input string name, input logic [15:0] op,
                         input logic ill, input logic [63:0] a0);
    exp_t r = '0;
    if (i < got_q.size()) r = got_q[i];
    check({name, "_op"}, r.ins.opcode, op);
    check({name, "_ill"}, r.ill, ill);
    check({name, "_arg0"}, r.ins.arg0, a0);
  endtask

  initial begin
    exp_t        m;
    logic [63:0] a [4];
    instruction_t snap;
    int          n;
    logic [63:0] h;
    int          cnt;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_illegal", out_illegal, 1'b0);
    check("rst_out_instr", out_instr, '0);
    check("rst_in_ready", in_ready, 1'b1);

    // Model pins: hand-computed results of the decode rules.
    a = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0, 64'h0, 64'h0};
    m = model_decode(64'h0000_0900_0000_0008, a);
    check("model_sext8", m.ins.arg0, 64'hFFFF_FFFF_FFFF_FF80);
    m = model_decode(64'h0000_0100_0000_0008, a);
    check("model_zext8", m.ins.arg0, 64'h80);
    m = model_decode(64'h0000_0200_0043_0008, a);
    check("model_badsize", {m.ill, m.ins.arg0}, {1'b1, 64'h0});

    // ADD with two 64-bit args, back-to-back.
    got_q.delete();
    src_q = '{64'h0000_0201_3333_0008, 64'h1111_2222_3333_4444, 64'h5};
    drain(50);
    check("add_count", got_q.size(), 1);
    chk_got(0, "add", 16'd8, 1'b0, 64'h1111_2222_3333_4444);
    if (got_q.size() > 0) begin
      check("add_arg1", got_q[0].ins.arg1, 64'h5);
      check("add_arg23", {got_q[0].ins.arg2, got_q[0].ins.arg3}, '0);
      check("add_flags", got_q[0].ins.flags, 8'h01);
      check("add_sizes", {got_q[0].ins.argSize0, got_q[0].ins.argSize3}, 8'h33);
    end
    check("add_latency", valid_cyc - hdr_cyc, 3);

    // Widening and sign extension.
    got_q.delete();
    src_q = '{64'h0000_0900_0000_0008, 64'hFFFF_FFFF_FFFF_FF80,
              64'h0000_0100_0000_0008, 64'hFFFF_FFFF_FFFF_FF80,
              64'h0000_0900_0002_0008, 64'h0000_0000_8000_0001};
    drain(60);
    check("ext_count", got_q.size(), 3);
    chk_got(0, "sext8", 16'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    chk_got(1, "zext8", 16'd8, 1'b0, 64'h80);
    chk_got(2, "sext32", 16'd8, 1'b0, 64'hFFFF_FFFF_8000_0001);

    // Illegal headers, each followed by a NOP header.
    got_q.delete();
    src_q = '{64'h0000_0000_0000_005B, 64'h0,
              64'h0000_0500_0000_0008, 64'h0,
              64'h0000_0200_0043_0008, 64'h0};
    drain(60);
    check("ill_count", got_q.size(), 6);
    chk_got(0, "bad_op", 16'h5B, 1'b1, 64'h0);
    chk_got(1, "nop_a", 16'h0, 1'b0, 64'h0);
    chk_got(2, "bad_cnt", 16'h8, 1'b1, 64'h0);
    chk_got(3, "nop_b", 16'h0, 1'b0, 64'h0);
    chk_got(4, "bad_size", 16'h8, 1'b1, 64'h0);
    chk_got(5, "nop_c", 16'h0, 1'b0, 64'h0);
    if (got_q.size() > 4) check("bad_size_copied", got_q[4].ins.argSize1, 4'd4);

    // Output backpressure.
    got_q.delete();
    ready_pct = 0;
    src_q = '{64'h0000_0100_0003_0008, 64'hABCD, 64'h1};
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_valid_seen", out_valid, 1'b1);
    snap = out_instr;
    repeat (10) tick();
    check("bp_stable", out_instr, snap);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_pending", src_q.size(), 1);
    ready_pct = 100;
    drain(50);
    chk_got(0, "bp_first", 16'd8, 1'b0, 64'hABCD);
    chk_got(1, "bp_next", 16'd1, 1'b0, 64'h0);

    // Flush after one of three args.
    got_q.delete();
    src_q = '{64'h0000_0300_3333_0008, 64'h77};
    n = 0;
    while (src_q.size() > 0 && n < 20) begin
      tick();
      n++;
    end
    flush_req = 1;
    tick();
    repeat (5) begin
      tick();
      check("flush_no_valid", out_valid, 1'b0);
    end
    src_q = '{64'h1};
    drain(50);
    check("flush_count", got_q.size(), 1);
    chk_got(0, "halt", 16'd1, 1'b0, 64'h0);
    if (got_q.size() > 0)
      check("halt_args", {got_q[0].ins.arg1, got_q[0].ins.arg2, got_q[0].ins.arg3}, '0);

    // Random legal/illegal stream with input gaps and output stalls.
    delivered = 0;
    valid_pct = 70;
    ready_pct = 60;
    for (int i = 0; i < 1000; i++) begin
      h = {$urandom, $urandom};
      h[15:0] = ($urandom_range(9) == 0) ? 16'($urandom_range(300, 91)) : 16'($urandom_range(90));
      cnt = ($urandom_range(9) == 0) ? int'($urandom_range(7, 5)) : int'($urandom_range(4));
      h[42:40] = 3'(cnt);
      for (int k = 0; k < 4; k++)
        h[16 + 4*k +: 4] = ($urandom_range(19) == 0) ? 4'($urandom_range(15, 4)) : 4'($urandom_range(3));
      src_q.push_back(h);
      for (int j = 0; j < model_need(h); j++) src_q.push_back({$urandom, $urandom});
    end
    drain(40000);
    check("rand_count", delivered, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
